mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting directly downstream of the execute-memory pipeline register. It takes the registered EX/MEM fields, runs load/store transactions on a req/ack data-memory port, and stalls upstream stages while a transaction is outstanding. It also loads the MEM/WB pipeline register that feeds writeback, and drops transactions that time out.

## Interface
- TIMEOUT_CYC, 255: REQ-state cycles without ack before the access is aborted (1..65535).
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- valid_i  in  1  EX/MEM valid
- reg_wr_i  in  1  EX/MEM register-write enable
- mem_to_reg_i  in  1  load indicator
- mem_wr_i  in  1  store indicator
- rd_i  in  5  destination register
- res_alu_i  in  32  ALU result / memory address
- r_data_p2_i  in  32  store data
- stall_o  out  1  holds PC, IF/ID, ID/EX and EX/MEM registers when high (combinational)
- dmem_req_o  out  1  memory request (registered)
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  byte address
- dmem_wdata_o  out  32  write data
- dmem_ack_i  in  1  transaction complete; rdata valid in the same cycle
- dmem_rdata_i  in  32  read data
- valid_wb_o, reg_wr_wb_o, mem_to_reg_wb_o  out  1 each  MEM/WB control
- rd_wb_o  out  5  MEM/WB destination
- res_alu_wb_o  out  32  MEM/WB ALU result
- r_data_wb_o  out  32  MEM/WB load data (0 for non-loads)
- bus_err_o  out  1  one-cycle pulse on timeout
- misalign_o  out  1  one-cycle pulse on misaligned access (tied 0 when the check is compiled out)

## Operation
- A memory op is valid_i & (mem_to_reg_i | mem_wr_i). A load and a store together are treated as a store.
- FSM has two states, IDLE and REQ.
- IDLE, no memory op: the MEM/WB register loads the inputs next edge (r_data_wb_o=0). stall_o=0.
- IDLE, memory op:
  - stall_o=1.
  - MEM/WB loads a bubble (all fields 0).
  - dmem_addr_o/wdata_o/we_o and the op's control fields are latched.
  - Wait counter cleared. Next state REQ.
- REQ:
  - dmem_req_o=1; addr/wdata/we held stable.
  - Counter increments each cycle; it is reset to 0 on entry to IDLE.
  - stall_o = ~dmem_ack_i & ~timeout.
- REQ with ack:
  - MEM/WB loads the latched op with valid=1 and r_data_wb_o=dmem_rdata_i (loads only).
  - dmem_req_o drops next cycle. Next state IDLE.
- REQ timeout: counter == TIMEOUT_CYC-1 with no ack.
  - bus_err_o pulses next cycle and the op is dropped (MEM/WB bubble).
  - Next state IDLE.
  - Ack in the timeout cycle takes priority: the access completes and there is no error.
- An ack in IDLE is ignored.
- valid_i=0 produces a MEM/WB bubble, no request.
- Reset (any time, including mid-REQ): all outputs 0, state IDLE, counter 0, outstanding request abandoned without writeback.

## Timing
- Non-memory op present in cycle N: MEM/WB valid at N+1.
- Memory op present in cycle N: req high N+1. Ack in cycle N+k (k≥1) → WB valid N+k+1, stall_o high N..N+k-1.
- Back-to-back memory ops: the second op is accepted in IDLE at N+k+1. Minimum 2 cycles per memory op.
- stall_o is combinational from state/ack/inputs. All other outputs are registered.

## Configuration
- MEM_STAGE_ALIGN_CHK_EN defined: a memory op in IDLE with res_alu_i[1:0]≠0 issues no request and does not stall. MEM/WB gets a bubble and misalign_o pulses at N+1.
- Undefined: no check; misaligned addresses pass to dmem_addr_o unchanged; misalign_o constant 0.

## Structure
- Shared package mips_pipe_pkg:
  - mem_state_t enum (IDLE=0, REQ=1)
  - REG_ADDR_W=5
  - DATA_W=32
- One sub-module, wb_pipe_reg: the MEM/WB register with clk/reset and a bubble input. All outputs reset to 0.
- FSM, counter and request latches live in mem_stage.

## Test plan
- ALU op (valid=1, reg_wr=1, rd=5, res_alu=0x1234) in IDLE → next cycle valid_wb=1, rd_wb=5, res_alu_wb=0x1234, r_data_wb=0, stall_o never high.
- Load at 0x100, ack after 3 REQ cycles with rdata=0xDEADBEEF → stall_o high 3 cycles, req high 3 cycles, then valid_wb=1, mem_to_reg_wb=1, r_data_wb=0xDEADBEEF, exactly one WB.
- Store addr 0x40 data 0xA5A5A5A5, ack in first REQ cycle → dmem_we=1, addr/wdata stable while req, 2-cycle occupancy, valid_wb=1, reg_wr_wb=0.
- TIMEOUT_CYC=4, no ack → req high 4 cycles, bus_err_o pulses once, no WB valid, stall released, next ALU op writes back normally.
- Reset asserted mid-REQ → dmem_req_o, stall_o and valid_wb_o go 0 immediately; a later ack is ignored.
- With MEM_STAGE_ALIGN_CHK_EN, load at 0x102 → no req, misalign_o pulse, valid_wb=0. Without the macro, a request is issued to 0x102.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: memory-stage FSM encoding and datapath widths.
package mips_pipe_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;
endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register; loads every cycle, bubble_i forces every field to zero.
module wb_pipe_reg
    import mips_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bubble_i,
    input  logic                  reg_wr_i,
    input  logic                  mem_to_reg_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0]     res_alu_i,
    input  logic [DATA_W-1:0]     r_data_i,
    output logic                  valid_o,
    output logic                  reg_wr_o,
    output logic                  mem_to_reg_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0]     res_alu_o,
    output logic [DATA_W-1:0]     r_data_o
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bubble_i) begin
            valid_o      <= 1'b0;
            reg_wr_o     <= 1'b0;
            mem_to_reg_o <= 1'b0;
            rd_o         <= '0;
            res_alu_o    <= '0;
            r_data_o     <= '0;
        end else begin
            valid_o      <= 1'b1;
            reg_wr_o     <= reg_wr_i;
            mem_to_reg_o <= mem_to_reg_i;
            rd_o         <= rd_i;
            res_alu_o    <= res_alu_i;
            r_data_o     <= r_data_i;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: req/ack data-memory FSM with timeout, stall and MEM/WB load.
// Optional alignment check enabled by defining MEM_STAGE_ALIGN_CHK_EN.
module mem_stage
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic                  reg_wr_i,
    input  logic                  mem_to_reg_i,
    input  logic                  mem_wr_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0]     res_alu_i,
    input  logic [DATA_W-1:0]     r_data_p2_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_W-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  valid_wb_o,
    output logic                  reg_wr_wb_o,
    output logic                  mem_to_reg_wb_o,
    output logic [REG_ADDR_W-1:0] rd_wb_o,
    output logic [DATA_W-1:0]     res_alu_wb_o,
    output logic [DATA_W-1:0]     r_data_wb_o,
    output logic                  bus_err_o,
    output logic                  misalign_o
);
    mem_state_t            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  we_q, reg_wr_q, m2r_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     addr_q, wdata_q;
    logic                  bus_err_q, bus_err_d;
    logic                  misalign_q, misalign_d;

    logic                  mem_op, misaligned, accept, timeout, stall;
    logic                  wb_bubble, wb_reg_wr, wb_m2r;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_res, wb_rdata;

    assign mem_op = valid_i & (mem_to_reg_i | mem_wr_i);
`ifdef MEM_STAGE_ALIGN_CHK_EN
    assign misaligned = mem_op & (res_alu_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign accept  = mem_op & ~misaligned;
    assign timeout = (state_q == REQ) & ~dmem_ack_i & (cnt_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        wb_bubble  = 1'b1;
        wb_reg_wr  = reg_wr_i;
        wb_m2r     = mem_to_reg_i;
        wb_rd      = rd_i;
        wb_res     = res_alu_i;
        wb_rdata   = '0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (accept) begin
                stall   = 1'b1;
                state_d = REQ;
            end else if (misaligned) begin
                misalign_d = 1'b1;
            end else begin
                wb_bubble = ~valid_i;
            end
        end else begin
            cnt_d     = cnt_q + 16'd1;
            wb_reg_wr = reg_wr_q;
            wb_m2r    = m2r_q;
            wb_rd     = rd_q;
            wb_res    = addr_q;
            if (dmem_ack_i) begin
                wb_bubble = 1'b0;
                wb_rdata  = m2r_q ? dmem_rdata_i : '0;
                state_d   = IDLE;
                cnt_d     = '0;
            end else if (timeout) begin
                bus_err_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end else begin
                stall = 1'b1;
            end
        end
    end

    // Gated so the stall releases immediately on reset even with a memory op still presented.
    assign stall_o = stall & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            reg_wr_q   <= 1'b0;
            m2r_q      <= 1'b0;
            rd_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
            if (state_q == IDLE && accept) begin
                // A combined load+store behaves as a store, so it never returns load data.
                we_q     <= mem_wr_i;
                reg_wr_q <= reg_wr_i;
                m2r_q    <= mem_to_reg_i & ~mem_wr_i;
                rd_q     <= rd_i;
                addr_q   <= res_alu_i;
                wdata_q  <= r_data_p2_i;
            end
        end
    end

    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign bus_err_o    = bus_err_q;
    assign misalign_o   = misalign_q;

    wb_pipe_reg u_wb_pipe_reg (
        .clk          (clk),
        .reset        (reset),
        .bubble_i     (wb_bubble),
        .reg_wr_i     (wb_reg_wr),
        .mem_to_reg_i (wb_m2r),
        .rd_i         (wb_rd),
        .res_alu_i    (wb_res),
        .r_data_i     (wb_rdata),
        .valid_o      (valid_wb_o),
        .reg_wr_o     (reg_wr_wb_o),
        .mem_to_reg_o (mem_to_reg_wb_o),
        .rd_o         (rd_wb_o),
        .res_alu_o    (res_alu_wb_o),
        .r_data_o     (r_data_wb_o)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized op/ack traffic against a transaction-level model.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, reg_wr_i, mem_to_reg_i, mem_wr_i;
    logic [4:0]  rd_i;
    logic [31:0] res_alu_i, r_data_p2_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_wb_o, reg_wr_wb_o, mem_to_reg_wb_o;
    logic [4:0]  rd_wb_o;
    logic [31:0] res_alu_wb_o, r_data_wb_o;
    logic        bus_err_o, misalign_o;

    int checks = 0;
    int failures = 0;
    int exp_err = 0, seen_err = 0;
    int exp_mis = 0, seen_mis = 0;

    // Expected writeback record: {rd, res_alu, reg_wr, mem_to_reg, r_data}
    logic [70:0] exp_q[$];

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .valid_i(valid_i), .reg_wr_i(reg_wr_i), .mem_to_reg_i(mem_to_reg_i), .mem_wr_i(mem_wr_i),
        .rd_i(rd_i), .res_alu_i(res_alu_i), .r_data_p2_i(r_data_p2_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_wb_o(valid_wb_o), .reg_wr_wb_o(reg_wr_wb_o), .mem_to_reg_wb_o(mem_to_reg_wb_o),
        .rd_wb_o(rd_wb_o), .res_alu_wb_o(res_alu_wb_o), .r_data_wb_o(r_data_wb_o),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every writeback must match the oldest expected record
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_err_o) seen_err++;
            if (misalign_o) seen_mis++;
            if (valid_wb_o) begin
                logic [70:0] obs, exp;
                obs = {rd_wb_o, res_alu_wb_o, reg_wr_wb_o, mem_to_reg_wb_o, r_data_wb_o};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected: got %h, none expected", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        failures++;
                        $display("FAIL wb_record: got %h expected %h", obs, exp);
                    end
                end
            end
        end
    end

    task automatic set_idle();
        valid_i = 0; reg_wr_i = 0; mem_to_reg_i = 0; mem_wr_i = 0;
        rd_i = 0; res_alu_i = 0; r_data_p2_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    endtask

    // Presents one EX/MEM op, plays the memory side (ack in REQ cycle ack_k, none if ack_k > TO),
    // and checks stall/request behaviour cycle by cycle. gap adds an idle cycle to check WB timing.
    task automatic do_op(input logic v, input logic rw, input logic m2r, input logic mw,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_k, input logic [31:0] rdata, input bit gap);
        logic is_mem, mis, exp_wb;
        is_mem = v & (m2r | mw);
        mis = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHK_EN
        mis = is_mem && (addr[1:0] != 2'b00);
`endif
        valid_i = v; reg_wr_i = rw; mem_to_reg_i = m2r; mem_wr_i = mw;
        rd_i = rd; res_alu_i = addr; r_data_p2_i = wd; dmem_ack_i = 0;
        if (!is_mem || mis) begin
            if (v && !is_mem) exp_q.push_back({rd, addr, rw, 1'b0, 32'h0});
            if (mis) exp_mis++;
            @(negedge clk);
            checks++;
            if (stall_o !== 1'b0) begin
                failures++; $display("FAIL stall_nonmem: got %b expected 0", stall_o);
            end
            @(posedge clk); #1;
        end else begin
            if (ack_k <= TO) exp_q.push_back({rd, addr, rw, m2r & ~mw, (m2r && !mw) ? rdata : 32'h0});
            else exp_err++;
            @(negedge clk);
            checks++;
            if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL accept_cycle: stall=%b req=%b expected stall=1 req=0", stall_o, dmem_req_o);
            end
            @(posedge clk); #1;
            for (int k = 1; k <= TO; k++) begin
                logic fin;
                fin = (k == ack_k) || (k == TO);
                dmem_ack_i = (k == ack_k);
                dmem_rdata_i = (k == ack_k) ? rdata : $urandom;
                @(negedge clk);
                checks++;
                if (dmem_req_o !== 1'b1 || dmem_addr_o !== addr || dmem_wdata_o !== wd || dmem_we_o !== mw) begin
                    failures++;
                    $display("FAIL req_cycle%0d: req=%b addr=%h wdata=%h we=%b expected 1 %h %h %b",
                             k, dmem_req_o, dmem_addr_o, dmem_wdata_o, dmem_we_o, addr, wd, mw);
                end
                checks++;
                if (stall_o !== !fin) begin
                    failures++;
                    $display("FAIL stall_req%0d: got %b expected %b", k, stall_o, !fin);
                end
                @(posedge clk); #1;
                if (fin) break;
            end
            dmem_ack_i = 0;
        end
        if (gap) begin
            valid_i = 0;
            exp_wb = (v && !is_mem) || (is_mem && !mis && ack_k <= TO);
            @(negedge clk);
            checks++;
            if (valid_wb_o !== exp_wb || dmem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL wb_timing: valid_wb=%b req=%b expected %b 0", valid_wb_o, dmem_req_o, exp_wb);
            end
            checks++;
            if (bus_err_o !== (is_mem && !mis && ack_k > TO) || misalign_o !== mis) begin
                failures++;
                $display("FAIL pulses: bus_err=%b misalign=%b expected %b %b",
                         bus_err_o, misalign_o, is_mem && !mis && ack_k > TO, mis);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({stall_o, dmem_req_o, dmem_we_o, valid_wb_o, bus_err_o, misalign_o} !== 6'b0 ||
            dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || res_alu_wb_o !== 32'h0 || r_data_wb_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: stall=%b req=%b vwb=%b addr=%h expected all 0",
                     stall_o, dmem_req_o, valid_wb_o, dmem_addr_o);
        end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        do_op(1, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 1, 32'h0, 1);
        do_op(0, 1, 1, 1, 5'd9, 32'h55, 32'h0, 1, 32'h0, 1);
    endtask

    task automatic test_load();
        do_op(1, 1, 1, 0, 5'd7, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1);
    endtask

    task automatic test_store();
        do_op(1, 0, 0, 1, 5'd0, 32'h40, 32'hA5A5A5A5, 1, 32'h0, 1);
        do_op(1, 1, 1, 1, 5'd3, 32'h44, 32'h12345678, 2, 32'hFFFF0000, 1);
    endtask

    task automatic test_timeout();
        do_op(1, 1, 1, 0, 5'd8, 32'h200, 32'h0, TO + 1, 32'h0, 1);
        checks++;
        if (bus_err_o !== 1'b0) begin
            failures++; $display("FAIL bus_err_pulse_width: got %b expected 0", bus_err_o);
        end
        do_op(1, 1, 0, 0, 5'd11, 32'hCAFE, 32'h0, 1, 32'h0, 1);
        do_op(1, 1, 1, 0, 5'd12, 32'h300, 32'h0, TO, 32'h0BADF00D, 1);
    endtask

    task automatic test_reset_mid_req();
        valid_i = 1; reg_wr_i = 1; mem_to_reg_i = 1; mem_wr_i = 0;
        rd_i = 5'd4; res_alu_i = 32'h80; dmem_ack_i = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || valid_wb_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_req: req=%b stall=%b vwb=%b expected 0 0 0", dmem_req_o, stall_o, valid_wb_o);
        end
        set_idle();
        @(posedge clk); #1;
        reset = 0;
        dmem_ack_i = 1; dmem_rdata_i = 32'h11112222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dmem_req_o !== 1'b0 || valid_wb_o !== 1'b0 || stall_o !== 1'b0) begin
                failures++;
                $display("FAIL late_ack_ignored: req=%b vwb=%b stall=%b expected 0 0 0", dmem_req_o, valid_wb_o, stall_o);
            end
            @(posedge clk); #1;
        end
        dmem_ack_i = 0;
    endtask

    task automatic test_misalign();
        do_op(1, 1, 1, 0, 5'd6, 32'h102, 32'h0, 1, 32'h77778888, 1);
    endtask

    task automatic test_back_to_back();
        do_op(1, 1, 1, 0, 5'd1, 32'h10, 32'h0, 1, 32'hAAAA0001, 0);
        do_op(1, 0, 0, 1, 5'd2, 32'h14, 32'hBBBB0002, 1, 32'h0, 0);
        do_op(1, 1, 1, 0, 5'd3, 32'h18, 32'h0, 2, 32'hCCCC0003, 0);
        do_op(1, 1, 0, 0, 5'd4, 32'h1C, 32'h0, 1, 32'h0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            case (kind)
                0: do_op(1, 1'($urandom), 0, 0, 5'($urandom), $urandom, $urandom, 1, 32'h0, 1'($urandom));
                1: do_op(0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, 1, 32'h0, 1'($urandom));
                2: do_op(1, 1, 1, 0, 5'($urandom), a, $urandom, $urandom_range(1, TO + 1), $urandom, 1'($urandom));
                3: do_op(1, 0, 0, 1, 5'($urandom), a, $urandom, $urandom_range(1, TO + 1), $urandom, 1'($urandom));
                default: do_op(1, 1'($urandom), 1, 1, 5'($urandom), a, $urandom, $urandom_range(1, TO + 1), $urandom, 1'($urandom));
            endcase
        end
        set_idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_req();
        test_misalign();
        test_back_to_back();
        test_random();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL wb_missing: %0d expected writebacks never seen", exp_q.size());
        end
        checks++;
        if (seen_err != exp_err) begin
            failures++; $display("FAIL bus_err_count: got %0d expected %0d", seen_err, exp_err);
        end
        checks++;
        if (seen_mis != exp_mis) begin
            failures++; $display("FAIL misalign_count: got %0d expected %0d", seen_mis, exp_mis);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
